// File: rtl/id_stage_hazard.sv
// Purpose: MIPS decode stage with register file, opcode decoder, load-use hazard FSM and ID/EX register.
// Latency: one cycle from IF/ID inputs to ID/EX outputs.
// Backpressure: ex_ready_i low freezes ID/EX and the FSM and raises stall_o. flush_i overrides everything.
// Optional: define ID_WB_BYPASS_EN for write-through of same-cycle write-back to register reads.
module id_stage_hazard #(
    parameter int XLEN             = 32,
    parameter int LOAD_USE_BUBBLES = 1,   // legal range 1..3
    parameter int PC_W             = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    input  logic [31:0]     if_instr_i,
    input  logic [PC_W-1:0] if_pc_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic            ex_valid_o,
    output logic [11:0]     ex_ctrl_o,
    output logic [4:0]      ex_rs_o,
    output logic [4:0]      ex_rt_o,
    output logic [4:0]      ex_rd_o,
    output logic [XLEN-1:0] ex_rdata1_o,
    output logic [XLEN-1:0] ex_rdata2_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [PC_W-1:0] ex_pc_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // Counter preload when entering STALL; only used when more than one bubble is needed.
    localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

    typedef enum logic {ST_RUN, ST_STALL} state_t;

    // ID/EX entry; a bubble is the all-zero value.
    typedef struct packed {
        logic            vld;
        logic [11:0]     ctrl;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
    } idex_t;

    logic [XLEN-1:0] r_regs [32];
    idex_t           r_idex;
    state_t          r_state;
    logic [1:0]      r_cnt;

    logic [5:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic [11:0]     w_ctrl;
    logic            w_rt_src;
    logic            w_hazard;
    idex_t           w_dec;

    assign w_op = if_instr_i[31:26];
    assign w_rs = if_instr_i[25:21];
    assign w_rt = if_instr_i[20:16];

    // Register file write port; register 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we_i && (wb_addr_i != 5'd0)) begin
            r_regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Combinational read ports, optionally forwarding the write-back value in the same cycle.
    always_comb begin
        w_rdata1 = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
        w_rdata2 = (w_rt == 5'd0) ? '0 : r_regs[w_rt];
`ifdef ID_WB_BYPASS_EN
        if (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == w_rs)) w_rdata1 = wb_data_i;
        if (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == w_rt)) w_rdata2 = wb_data_i;
`endif
    end

    // Opcode decoder: control word layout {alu_op[2:0], load_mode[1:0], branch, mem_to_reg, mem_read, mem_write, alu_src, reg_write, reg_dst}.
    always_comb begin
        w_ctrl   = 12'h000;
        w_rt_src = 1'b0;
        unique case (w_op)
            OP_RTYPE: begin w_ctrl = {3'b010, 2'b00, 7'b0000011}; w_rt_src = 1'b1; end
            OP_LW:    w_ctrl = {3'b000, 2'b00, 7'b0110110};
            OP_LH:    w_ctrl = {3'b000, 2'b01, 7'b0110110};
            OP_LB:    w_ctrl = {3'b000, 2'b10, 7'b0110110};
            OP_SW:    begin w_ctrl = {3'b000, 2'b00, 7'b0001100}; w_rt_src = 1'b1; end
            OP_BEQ:   begin w_ctrl = {3'b001, 2'b00, 7'b1000000}; w_rt_src = 1'b1; end
            OP_ADDI:  w_ctrl = {3'b000, 2'b00, 7'b0000110};
            OP_ANDI:  w_ctrl = {3'b011, 2'b00, 7'b0000110};
            OP_ORI:   w_ctrl = {3'b100, 2'b00, 7'b0000110};
            default:  w_ctrl = 12'h000;
        endcase
    end

    // Assemble the next ID/EX entry from the instruction in ID.
    always_comb begin
        w_dec        = '0;
        w_dec.vld    = if_valid_i;
        w_dec.ctrl   = w_ctrl;
        w_dec.rs     = w_rs;
        w_dec.rt     = w_rt;
        w_dec.rd     = if_instr_i[15:11];
        w_dec.rdata1 = w_rdata1;
        w_dec.rdata2 = w_rdata2;
        w_dec.pc     = if_pc_i;
        if ((w_op == OP_ANDI) || (w_op == OP_ORI)) begin
            w_dec.imm = {{(XLEN-16){1'b0}}, if_instr_i[15:0]};
        end else begin
            w_dec.imm = {{(XLEN-16){if_instr_i[15]}}, if_instr_i[15:0]};
        end
    end

    // Load in EX whose destination is read by the instruction in ID; $0 never creates a hazard.
    assign w_hazard = r_idex.vld && r_idex.ctrl[4] && (r_idex.rt != 5'd0) && if_valid_i &&
                      ((r_idex.rt == w_rs) || (w_rt_src && (r_idex.rt == w_rt)));

    // Stall request: flush wins, then EX backpressure, then the bubble sequence.
    always_comb begin
        if (flush_i) begin
            stall_o = 1'b0;
        end else if (!ex_ready_i) begin
            stall_o = 1'b1;
        end else if (r_state == ST_STALL) begin
            stall_o = 1'b1;
        end else begin
            stall_o = w_hazard;
        end
    end

    // Hazard FSM and ID/EX register update in priority order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex  <= '0;
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else if (flush_i) begin
            r_idex  <= '0;
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else if (ex_ready_i) begin
            if (r_state == ST_STALL) begin
                r_idex <= '0;
                r_cnt  <= r_cnt - 2'd1;
                if (r_cnt <= 2'd1) begin
                    r_state <= ST_RUN;
                end
            end else if (w_hazard) begin
                r_idex <= '0;
                if (LOAD_USE_BUBBLES > 1) begin
                    r_cnt   <= BUB_INIT;
                    r_state <= ST_STALL;
                end
            end else begin
                r_idex <= w_dec;
            end
        end
    end

    assign ex_valid_o  = r_idex.vld;
    assign ex_ctrl_o   = r_idex.ctrl;
    assign ex_rs_o     = r_idex.rs;
    assign ex_rt_o     = r_idex.rt;
    assign ex_rd_o     = r_idex.rd;
    assign ex_rdata1_o = r_idex.rdata1;
    assign ex_rdata2_o = r_idex.rdata2;
    assign ex_imm_o    = r_idex.imm;
    assign ex_pc_o     = r_idex.pc;

endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
- Parametrised next-generation MIPS decode stage; sits between the IF/ID register and the EX stage.
- Contains the 32-entry register file, the opcode decoder and the ID/EX pipeline register.
- Adds what the previous decode stage lacks: asynchronous reset, valid/backpressure handshake, and load-use hazard detection with a configurable bubble count.
- Adds flush for taken branches and a configurable datapath width.

Parameters:
- XLEN, 32, datapath and register width; the immediate is extended to XLEN.
- LOAD_USE_BUBBLES, 1, bubbles inserted on a load-use hazard; legal range 1..3.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid_i  in  1  IF/ID holds a valid instruction.
- if_instr_i  in  32  instruction word.
- if_pc_i  in  PC_W  PC+4 of the instruction.
- flush_i  in  1  taken branch resolved in EX; kill the instruction in ID.
- ex_ready_i  in  1  EX can accept a new ID/EX entry this cycle.
- wb_we_i  in  1  write-back enable.
- wb_addr_i  in  5  write-back register index.
- wb_data_i  in  XLEN  write-back data.
- stall_o  out  1  hold the PC and IF/ID this cycle.
- ex_valid_o  out  1  ID/EX holds a real instruction.
- ex_ctrl_o  out  12  packed control word:
  - [0] reg_dst, [1] reg_write, [2] alu_src, [3] mem_write, [4] mem_read
  - [5] mem_to_reg, [6] branch, [8:7] load_mode, [11:9] alu_op
- ex_rs_o, ex_rt_o, ex_rd_o  out  5 each  instruction bits [25:21], [20:16], [15:11].
- ex_rdata1_o, ex_rdata2_o  out  XLEN each  register operands.
- ex_imm_o  out  XLEN  extended immediate.
- ex_pc_o  out  PC_W  forwarded PC+4.

Behaviour:
- Reset (async, rst_n low):
  - all ID/EX outputs 0, ex_valid_o 0.
  - FSM to RUN, bubble counter 0, all registers 0.
- Register file:
  - synchronous write on the rising edge when wb_we_i and wb_addr_i != 0.
  - register 0 always reads 0; reads are combinational.
- Decode. Fields not listed are 0; an unknown opcode gives an all-zero control word with valid still propagated.
  - 000000 R-type: reg_dst, reg_write, alu_op 010.
  - 100011 lw: alu_src, reg_write, mem_read, mem_to_reg, load_mode 00, alu_op 000.
  - 100001 lh: as lw with load_mode 01.
  - 100000 lb: as lw with load_mode 10.
  - 101011 sw: alu_src, mem_write, alu_op 000.
  - 000100 beq: branch, alu_op 001.
  - 001000 addi: alu_src, reg_write, alu_op 000.
  - 001100 andi: alu_src, reg_write, alu_op 011.
  - 001101 ori: alu_src, reg_write, alu_op 100.
- Immediate: andi and ori zero-extend; every other opcode sign-extends.
- Hazard (combinational): asserted when all of the following hold:
  - ex_valid_o, ex_ctrl_o[4], ex_rt_o != 0 and if_valid_i;
  - ex_rt_o == rs, or ex_rt_o == rt with rt used as a source (R-type, sw, beq).
- FSM states and stall_o:
  - RUN: stall_o = hazard.
    - On hazard with ex_ready_i: ID/EX loads a bubble (valid 0, ctrl 0).
    - If LOAD_USE_BUBBLES > 1, load the counter with LOAD_USE_BUBBLES-1 and go to STALL.
  - STALL: stall_o = 1; ID/EX loads a bubble and the counter decrements on each cycle with ex_ready_i.
    - When the counter reaches 0, return to RUN.
- Latency: one cycle, ID input to ID/EX output.
- ID/EX update rules, highest priority first:
  1. flush_i: ID/EX gets a bubble, FSM to RUN, counter cleared, stall_o 0. flush_i overrides a hazard in the same cycle.
  2. ex_ready_i low: ID/EX holds, FSM frozen, stall_o 1.
  3. Hazard or STALL: bubble.
  4. Otherwise: load the decoded instruction, with ex_valid_o = if_valid_i.
- Write-back and read of the same register in the same cycle: see Optional Feature.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: a read whose index equals wb_addr_i, with wb_we_i high and index != 0, returns wb_data_i in the same cycle (write-through).
- Undefined: the read returns the old register value, and the write becomes visible the following cycle.

Test Plan:
- Reset mid-operation: assert rst_n low while ex_valid_o=1 -> all outputs 0 immediately, without waiting for a clock edge.
- lw $2,4($1) then add $3,$2,$4, LOAD_USE_BUBBLES=1 -> stall_o=1 for exactly one cycle; one bubble (ex_valid_o=0); add reaches ID/EX one cycle later with ctrl 0x403.
- Same sequence with LOAD_USE_BUBBLES=3 -> stall_o=1 for 3 cycles and 3 bubbles; with flush_i pulsed in the 2nd stall cycle, stall_o drops at once and the FSM returns to RUN.
- Write-back to register 5 with 0xDEADBEEF in the same cycle as a read of register 5 -> ex_rdata1_o=0xDEADBEEF with ID_WB_BYPASS_EN defined, old value without it; a write to register 0 always reads back 0.
- ex_ready_i low for 2 cycles with addi $1,$0,-1 in ID -> ID/EX holds its prior contents and stall_o=1; after release, ex_imm_o=0xFFFFFFFF. ori with imm 0xFFFF -> ex_imm_o=0x0000FFFF.
- lw $0,0($1) followed by add using $0 -> no stall, since hazards on register 0 are ignored.
